sar_controller: RTL and testbench
=================================

SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 Parameter Ndac, default 16, is the number of DAC bits and the width of dac_state and result; legal range 2..32.
REQ-002 Parameter Nsamp, default 2, is the number of clock cycles spent in the sample phase; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  conversion request, level-sampled on each rising edge.
REQ-006 comp_out  input  1  comparator decision; 1 = trial DAC code above input (trial too high).
REQ-007 sample  output  1  high while the array tracks the input.
REQ-008 comp_en  output  1  comparator strobe, one cycle per bit trial.
REQ-009 dac_state  output  Ndac  capacitor-array control bus, drives the CDAC dac_state port directly.
REQ-010 busy  output  1  high from start acceptance until done.
REQ-011 done  output  1  single-cycle pulse: result valid.
REQ-012 result  output  Ndac  final conversion code.

Function
REQ-013 FSM states: IDLE, SAMPLE, CMP, DEC, DONE; all outputs driven from registers, no combinational path from inputs to outputs.
REQ-014 IDLE: sample=0, comp_en=0, busy=0, dac_state=0; start=1 -> SAMPLE, sample-cycle counter cleared.
REQ-015 SAMPLE: sample=1, busy=1, dac_state=0; lasts exactly Nsamp cycles, then -> CMP with dac_state = only bit Ndac-1 set, bit index i = Ndac-1.
REQ-016 CMP: comp_en=1 for exactly one cycle, dac_state stable; -> DEC.
REQ-017 DEC: comp_out sampled at end of cycle; comp_out=1 clears bit i, comp_out=0 keeps bit i; if i>0, bit i-1 is set in the same update, i decrements, -> CMP; if i=0 -> DONE.
REQ-018 Each bit costs exactly 2 cycles (CMP+DEC); bits resolved MSB first; bits above i are never modified after their DEC.
REQ-019 DONE: done=1 for one cycle, busy=0, result loaded with final dac_state in the same edge that enters DONE; dac_state holds the final code during DONE.
REQ-020 Latency: if start is sampled at edge E, done is high in the cycle after edge E+Nsamp+2*Ndac.
REQ-021 From DONE: start=1 -> SAMPLE directly (back-to-back, no idle cycle); start=0 -> IDLE.
REQ-022 start while busy (SAMPLE/CMP/DEC) is ignored, not queued.
REQ-023 result holds its value until the next DONE entry; unchanged by a subsequent start or by an aborted conversion.
REQ-024 comp_out is ignored in all states except DEC.

Reset
REQ-025 rst_n=0 at a rising edge: state=IDLE, dac_state=0, result=0, sample=0, comp_en=0, busy=0, done=0, bit index and counters cleared.
REQ-026 Reset mid-conversion aborts immediately; no done pulse; first legal start after release begins a fresh conversion with the REQ-020 latency.
REQ-027 start sampled while rst_n=0 is discarded.

Verification (Ndac=4, Nsamp=2, comparator model comp_out = (dac_state > vin))
REQ-028 vin=11 (4'b1011), start pulsed at edge E -> dac_state trials 1000,1100,1010,1011; done high after edge E+10; result=4'b1011.
REQ-029 comp_out tied 1 -> result=4'b0000; comp_out tied 0 -> result=4'b1111; each with exactly 4 comp_en pulses.
REQ-030 start held high continuously, vin=5 -> successive conversions every 11 cycles, each result=4'b0101, busy low only in DONE cycles.
REQ-031 start re-asserted during CMP/DEC of a conversion -> no effect on trial sequence, single done pulse, no extra conversion.
REQ-032 rst_n low for one cycle during third bit trial -> all outputs 0 next cycle, result stays 0, no done; next start with vin=6 -> result=4'b0110.

Source files
------------

// File: rtl/sar_controller.sv
// Successive-approximation ADC controller: samples, then resolves one
// DAC bit per CMP/DEC pair, MSB first, and reports the final code.
module sar_controller #(
    parameter int Ndac  = 16,
    parameter int Nsamp = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            comp_out,
    output logic            sample,
    output logic            comp_en,
    output logic [Ndac-1:0] dac_state,
    output logic            busy,
    output logic            done,
    output logic [Ndac-1:0] result
);

    localparam int IW = $clog2(Ndac);
    localparam logic [IW-1:0]   IDX_TOP  = IW'(Ndac - 1);
    localparam logic [7:0]      CNT_LAST = 8'(Nsamp - 1);
    localparam logic [Ndac-1:0] DAC_MSB  = {1'b1, {(Ndac-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CMP,
        S_DEC,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic [IW-1:0]   r_idx;
    logic [Ndac-1:0] r_dac;
    logic [Ndac-1:0] r_result;
    logic            r_sample;
    logic            r_comp_en;
    logic            r_busy;
    logic            r_done;
    logic [Ndac-1:0] w_dec;

    // Trial update: drop the bit under test if too high, arm the next one.
    always_comb begin
        w_dec = r_dac;
        if (comp_out)
            w_dec[r_idx] = 1'b0;
        if (r_idx != '0)
            w_dec[r_idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_dac     <= '0;
            r_result  <= '0;
            r_sample  <= 1'b0;
            r_comp_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_comp_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_dac <= '0;
                    if (start) begin
                        r_state  <= S_SAMPLE;
                        r_cnt    <= '0;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state   <= S_CMP;
                        r_sample  <= 1'b0;
                        r_dac     <= DAC_MSB;
                        r_idx     <= IDX_TOP;
                        r_comp_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_CMP: begin
                    r_state <= S_DEC;
                end
                S_DEC: begin
                    r_dac <= w_dec;
                    if (r_idx == '0) begin
                        r_state  <= S_DONE;
                        r_result <= w_dec;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_idx     <= r_idx - 1'b1;
                        r_state   <= S_CMP;
                        r_comp_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_dac <= '0;
                    if (start) begin
                        r_state  <= S_SAMPLE;
                        r_cnt    <= '0;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sample    = r_sample;
    assign comp_en   = r_comp_en;
    assign dac_state = r_dac;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;

endmodule

// File: tb/tb_sar_controller.sv
// Bench for sar_controller (Ndac=4, Nsamp=2) with a behavioural
// comparator and a binary-search reference for trials and results.
module tb_sar_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       comp_out;
    logic       sample;
    logic       comp_en;
    logic [3:0] dac_state;
    logic       busy;
    logic       done;
    logic [3:0] result;

    logic [3:0] vin;
    logic [1:0] mode;
    logic [3:0] last_res;
    int         n_err;
    int         n_checks;

    sar_controller #(.Ndac(4), .Nsamp(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .comp_out  (comp_out),
        .sample    (sample),
        .comp_en   (comp_en),
        .dac_state (dac_state),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // mode 0: real comparator, 1: tied high, 2: tied low
    assign comp_out = (mode == 2'd1) ? 1'b1 :
                      (mode == 2'd2) ? 1'b0 : (dac_state > vin);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Trial code presented while resolving bit b: upper bits already
    // settled to the effective input, bit b set, lower bits clear.
    function automatic logic [31:0] trial(input int ev, input int b);
        return ((ev >> (b + 1)) << (b + 1)) | (1 << b);
    endfunction

    // Called at a negedge with the DUT idle; start is sampled at the next edge.
    task automatic run_conv(input logic [3:0] v, input logic [1:0] m,
                            input bit reassert);
        int ev;
        vin  = v;
        mode = m;
        ev   = (m == 2'd1) ? 0 : (m == 2'd2) ? 15 : int'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= 10; j++) begin
            if (j > 0) @(negedge clk);
            chk("busy", busy, 32'(j < 10));
            chk("done", done, 32'(j == 10));
            chk("sample", sample, 32'(j < 2));
            chk("comp_en", comp_en, 32'(j >= 2 && j < 10 && j % 2 == 0));
            if (j < 2)
                chk("dac_sample", dac_state, 0);
            else if (j < 10)
                chk("dac_trial", dac_state, trial(ev, 3 - (j - 2) / 2));
            if (j < 10)
                chk("result_hold", result, last_res);
            else begin
                chk("result", result, 32'(ev));
                chk("dac_final", dac_state, 32'(ev));
            end
            if (reassert && j == 5) start = 1'b1;
            if (reassert && j == 6) start = 1'b0;
        end
        last_res = 4'(ev);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_dac", dac_state, 0);
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        vin      = 4'd0;
        mode     = 2'd0;
        last_res = 4'd0;
        rst_n    = 1'b0;
        start    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sample", sample, 0);
        chk("rst_comp_en", comp_en, 0);
        chk("rst_dac", dac_state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_start_discard", busy, 0);
        end

        run_conv(4'd11, 2'd0, 1'b0);
        run_conv(4'd0, 2'd1, 1'b0);
        run_conv(4'd0, 2'd2, 1'b0);
        run_conv(4'd3, 2'd0, 1'b1);

        // Back-to-back conversions with start held high
        vin   = 4'd5;
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        for (int j = 0; j <= 32; j++) begin
            bit p;
            if (j > 0) @(negedge clk);
            p = (j >= 10) && ((j - 10) % 11 == 0);
            chk("b2b_busy", busy, 32'(!p));
            chk("b2b_done", done, 32'(p));
            if (p) chk("b2b_result", result, 5);
        end
        start = 1'b0;
        last_res = 4'd5;
        @(negedge clk);
        chk("b2b_idle", busy, 0);

        // Reset during the third bit trial
        vin   = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_cmp", comp_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sample", sample, 0);
        chk("abort_comp_en", comp_en, 0);
        chk("abort_dac", dac_state, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        rst_n = 1'b1;
        last_res = 4'd0;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_conv(4'd6, 2'd0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_conv(4'($urandom_range(15, 0)), 2'd0, 1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
